// File: rtl/uart_mmio.sv
// Memory-mapped UART: one transmit register, one receive register and two
// status words. 8N1 framing, fixed CLKS_PER_BIT clock cycles per bit.
//
// Register map (byte addresses):
//   UART_TX_ADDR  write: start a frame when idle (ignored while busy); reads 0
//   UART_RX_ADDR  read : last received byte, zero-extended
//   UART_TX_DONE  read : 1 when the transmitter can accept a byte
//   UART_RX_DONE  read : 1 after a byte arrives; any write clears it
//
// Bus handshake: bus_wren is a single-cycle store strobe qualified by
// bus_addr; there is no ready/stall, so a TX write issued while tx_ready=0
// is dropped. Reads are combinational from bus_addr and have no side effects.

package mem_pkg;
  localparam logic [31:0] UART_TX_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_RX_ADDR = 32'h1000_0004;
  localparam logic [31:0] UART_TX_DONE = 32'h1000_0008;
  localparam logic [31:0] UART_RX_DONE = 32'h1000_000C;
endpackage

module uart_mmio
  import mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic        bus_wren,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] uart_rddata
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Start-bit confirmation point: CLKS_PER_BIT/2 cycles after the falling edge
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic tx_wr;
  logic rx_clr;
  logic unused_wrdata;

  assign tx_wr         = bus_wren && (bus_addr == UART_TX_ADDR);
  assign rx_clr        = bus_wren && (bus_addr == UART_RX_DONE);
  assign unused_wrdata = ^bus_wrdata[31:8];

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  uart_state_e   tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_ready_q;
  logic          tx_q;

  // TX FSM: the line level is registered alongside the state so every
  // transition drives the next bit directly, with no decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= 8'h00;
      tx_ready_q <= 1'b1;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          if (tx_wr && tx_ready_q) begin
            tx_shift_q <= bus_wrdata[7:0];
            tx_state_q <= S_START;
            tx_cnt_q   <= '0;
            tx_ready_q <= 1'b0;
            tx_q       <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= S_DATA;
            tx_q       <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= S_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_q     <= tx_shift_q[tx_bit_q + 3'd1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          // Ready rises on the edge the stop bit ends, so a write in the very
          // next cycle starts a back-to-back frame.
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= S_IDLE;
            tx_ready_q <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        default: begin
          tx_state_q <= S_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx = tx_q;

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic          rx_sync1_q;
  logic          rx_sync2_q;
  logic          rx_s;
  uart_state_e   rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_done_q;
  logic          rx_done_d;
  logic          rx_ferr_q;
  logic          rx_complete;

  assign rx_s = rx_sync2_q;

  // A good stop bit completes the byte this cycle.
  assign rx_complete = (rx_state_q == S_STOP) && !rx_ferr_q &&
                       (rx_cnt_q == CNT_LAST) && rx_s;

  // Done flag: a completing byte overrides a simultaneous clear.
  always_comb begin
    rx_done_d = rx_done_q;
    if (rx_clr)      rx_done_d = 1'b0;
    if (rx_complete) rx_done_d = 1'b1;
  end

  // RX synchronizer, FSM and result registers; samples are taken mid-bit
  // relative to the detected falling edge of the start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_done_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync1_q <= uart_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_done_q  <= rx_done_d;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s) begin
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            // A line back high at mid-start was a glitch, not a frame.
            rx_state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q             <= '0;
            rx_shift_q[rx_bit_q] <= rx_s;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (rx_ferr_q) begin
            // Framing error: hold off until the line idles high again.
            if (rx_s) begin
              rx_ferr_q  <= 1'b0;
              rx_state_q <= S_IDLE;
            end
          end else if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_s) begin
              rx_data_q  <= rx_shift_q;
              rx_state_q <= S_IDLE;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        default: begin
          rx_state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  // Combinational read data; the TX data register reads back as zero.
  always_comb begin
    uart_rddata = 32'h0;
    case (bus_addr)
      UART_RX_ADDR: uart_rddata = {24'b0, rx_data_q};
      UART_TX_DONE: uart_rddata = {31'b0, tx_ready_q};
      UART_RX_DONE: uart_rddata = {31'b0, rx_done_q};
      default:      uart_rddata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Testbench for uart_mmio at 4 clocks per bit. A frame-level model predicts
// the serial TX line and the status/read registers; a negedge process
// compares the DUT against it every cycle, and directed sections pin the
// model with hand-derived literal waveforms and register values.

module tb_uart_mmio;
  import mem_pkg::*;

  localparam int C = 4;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic        bus_wren;
  logic        uart_rx;
  logic        uart_tx;
  logic [31:0] uart_rddata;

  always #5 clk = ~clk;

  uart_mmio #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wrdata (bus_wrdata),
    .bus_wren   (bus_wren),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .uart_rddata(uart_rddata)
  );

  // ---------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // TX: a frame is the 10-bit vector {stop, data, start}; the line shows
  // bit (elapsed / C) while cycles remain, and the TX is ready at zero.
  // RX: expected byte/flag are set by the driver once a frame is fully sent;
  // rx_stable=0 marks the window where the DUT may legitimately be updating.
  // ---------------------------------------------------------------------
  int         m_tx_rem = 0;
  logic [9:0] m_frame  = 10'h3FF;
  bit         started  = 1'b0;
  logic       m_rx_done;
  logic [7:0] m_rx_data;
  bit         rx_stable;
  bit         rand_addr;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_tx_rem = 0;
    end else if (m_tx_rem > 0) begin
      m_tx_rem = m_tx_rem - 1;
    end else if (bus_wren && bus_addr == UART_TX_ADDR) begin
      m_tx_rem = 10 * C;
      m_frame  = {1'b1, bus_wrdata[7:0], 1'b0};
    end
  end

  function automatic logic exp_tx();
    if (m_tx_rem == 0) return 1'b1;
    return m_frame[(10 * C - m_tx_rem) / C];
  endfunction

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("uart_tx", {31'b0, uart_tx}, {31'b0, exp_tx()});
      if (bus_addr == UART_TX_DONE)
        check("rd_tx_done", uart_rddata, {31'b0, (m_tx_rem == 0)});
      else if (bus_addr == UART_RX_ADDR) begin
        if (rx_stable) check("rd_rx_data", uart_rddata, {24'b0, m_rx_data});
      end else if (bus_addr == UART_RX_DONE) begin
        if (rx_stable) check("rd_rx_done", uart_rddata, {31'b0, m_rx_done});
      end else
        check("rd_other", uart_rddata, 32'h0);
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return UART_TX_ADDR;
      1:       return UART_RX_ADDR;
      2:       return UART_TX_DONE;
      3:       return UART_RX_DONE;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_addr && !bus_wren) bus_addr = pick_addr();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_addr   = addr;
    bus_wrdata = data;
    bus_wren   = 1'b1;
    tick();
    bus_wren = 1'b0;
    if (addr == UART_RX_DONE) m_rx_done = 1'b0;
    if (rand_addr) bus_addr = pick_addr();
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (stop) rx_stable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (C) tick();
    end
    uart_rx = 1'b1;
    repeat (3 * C) tick();
    if (stop) begin
      m_rx_data = d;
      m_rx_done = 1'b1;
      rx_stable = 1'b1;
    end
  endtask

  task automatic rx_glitch();
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (3 * C) tick();
  endtask

  // Write d, optionally a second byte 'second_at' cycles later, and capture
  // the line at the start of each bit plus the number of busy cycles.
  task automatic tx_capture(input logic [7:0] d, input int second_at, input logic [7:0] d2,
                            output logic [9:0] bits, output int busy);
    bus_addr   = UART_TX_ADDR;
    bus_wrdata = {24'b0, d};
    bus_wren   = 1'b1;
    tick();
    bus_wren = 1'b0;
    bus_addr = UART_TX_DONE;
    busy     = 0;
    bits     = '0;
    for (int c = 0; c < 10 * C; c++) begin
      if (c % C == 0) bits[c / C] = uart_tx;
      if (uart_rddata == 32'h0) busy++;
      if (c == second_at) begin
        bus_addr   = UART_TX_ADDR;
        bus_wrdata = {24'b0, d2};
        bus_wren   = 1'b1;
      end
      tick();
      bus_wren = 1'b0;
      bus_addr = UART_TX_DONE;
    end
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [9:0] bits;
    logic [9:0] rxf;
    int         busy;
    int         hi;

    rst        = 1'b1;
    bus_addr   = UART_TX_DONE;
    bus_wrdata = 32'h0;
    bus_wren   = 1'b0;
    uart_rx    = 1'b1;
    rand_addr  = 1'b0;
    rx_stable  = 1'b1;
    m_rx_done  = 1'b0;
    m_rx_data  = 8'h00;

    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_tx_done", uart_rddata, 32'h1);
    bus_addr = UART_RX_DONE; #1;
    check("rst_rx_done", uart_rddata, 32'h0);
    bus_addr = UART_RX_ADDR; #1;
    check("rst_rx_data", uart_rddata, 32'h0);
    bus_addr = UART_TX_DONE;
    tick();

    // 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 and 40 busy cycles
    tx_capture(8'hA5, -1, 8'h00, bits, busy);
    check("tx_a5_bits", {22'b0, bits}, {22'b0, 10'b1101001010});
    check("tx_a5_busy", busy, 40);
    check("tx_a5_ready", uart_rddata, 32'h1);
    repeat (5) tick();

    // Write while busy is dropped
    tx_capture(8'hA5, 10, 8'h3C, bits, busy);
    check("tx_busy_bits", {22'b0, bits}, {22'b0, 10'b1101001010});
    check("tx_busy_busy", busy, 40);
    hi = 0;
    repeat (48) begin
      if (uart_tx) hi++;
      tick();
    end
    check("tx_busy_no_3c", hi, 48);

    // RX 0x5A, then clear
    send_rx(8'h5A, 1'b1);
    bus_addr = UART_RX_DONE; #1;
    check("rx_5a_done", uart_rddata, 32'h1);
    bus_addr = UART_RX_ADDR; #1;
    check("rx_5a_data", uart_rddata, 32'h5A);
    bus_write(UART_RX_DONE, 32'h0);
    check("rx_clear", uart_rddata, 32'h0);

    // Glitch and framing error
    rx_glitch();
    bus_addr = UART_RX_DONE; #1;
    check("rx_glitch_done", uart_rddata, 32'h0);
    send_rx(8'hFF, 1'b0);
    check("rx_ferr_done", uart_rddata, 32'h0);
    bus_addr = UART_RX_ADDR; #1;
    check("rx_ferr_data", uart_rddata, 32'h5A);

    // Reset mid-frame on both directions
    bus_addr = UART_TX_DONE;
    tick();
    rx_stable  = 1'b0;
    rxf        = {1'b1, 8'h5A, 1'b0};
    bus_addr   = UART_TX_ADDR;
    bus_wrdata = 32'h0000_00A5;
    bus_wren   = 1'b1;
    tick();
    bus_wren = 1'b0;
    bus_addr = UART_TX_DONE;
    for (int c = 0; c < 15; c++) begin
      uart_rx = rxf[c / C];
      tick();
    end
    rst     = 1'b1;
    uart_rx = 1'b1;
    tick();
    rst       = 1'b0;
    m_rx_done = 1'b0;
    m_rx_data = 8'h00;
    rx_stable = 1'b1;
    check("rstmid_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("rstmid_tx_done", uart_rddata, 32'h1);
    bus_addr = UART_RX_DONE; #1;
    check("rstmid_rx_done", uart_rddata, 32'h0);
    bus_addr = UART_TX_DONE;
    repeat (3) tick();

    // Clean 0x81 in both directions after the abort
    tx_capture(8'h81, -1, 8'h00, bits, busy);
    check("tx_81_bits", {22'b0, bits}, {22'b0, 10'b1100000010});
    send_rx(8'h81, 1'b1);
    bus_addr = UART_RX_ADDR; #1;
    check("rx_81_data", uart_rddata, 32'h81);
    bus_addr = UART_RX_DONE; #1;
    check("rx_81_done", uart_rddata, 32'h1);
    bus_addr = UART_TX_DONE;
    tick();

    // Randomized traffic
    rand_addr = 1'b1;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          bus_write(UART_TX_ADDR, $urandom);
          repeat ($urandom_range(0, 50)) tick();
        end
        3, 4, 5: send_rx(8'($urandom), ($urandom_range(0, 7) != 0));
        6:       bus_write(UART_RX_DONE, $urandom);
        7: begin
          case ($urandom_range(0, 2))
            0:       bus_write(UART_RX_ADDR, $urandom);
            1:       bus_write(UART_TX_DONE, $urandom);
            default: bus_write($urandom, $urandom);
          endcase
        end
        8:       rx_glitch();
        default: repeat ($urandom_range(1, 20)) tick();
      endcase
    end
    rand_addr = 1'b0;
    bus_addr  = UART_TX_DONE;
    repeat (60) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit; legal values are 4 or more.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port bus_addr  input  32  data-bus byte address, compared against mem_pkg UART_TX_ADDR, UART_RX_ADDR, UART_TX_DONE and UART_RX_DONE.
REQ-005 SHALL have port bus_wrdata  input  32  store data; only bits [7:0] are used.
REQ-006 SHALL have port bus_wren  input  1  store strobe, qualified by bus_addr.
REQ-007 SHALL have port uart_rx  input  1  serial input, asynchronous, idle high.
REQ-008 SHALL have port uart_tx  output  1  serial output, idle high.
REQ-009 SHALL have port uart_rddata  output  32  register read data, combinational from bus_addr.

Function
REQ-010 SHALL return read data as follows:
- UART_RX_ADDR: {24'b0, rx_data}.
- UART_TX_DONE: {31'b0, tx_ready}.
- UART_RX_DONE: {31'b0, rx_done}.
- UART_TX_ADDR and all other addresses: 32'h0.
REQ-011 SHALL treat a cycle with bus_wren=1 and bus_addr=UART_TX_ADDR while tx_ready=1 as a TX start: latch bus_wrdata[7:0], then tx_ready=0 from the next cycle.
REQ-012 SHALL ignore TX writes while tx_ready=0; the frame in flight and its latched byte are unchanged.
REQ-013 SHALL run a TX FSM with states IDLE, START, DATA, STOP.
- IDLE: uart_tx=1.
- START: uart_tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles, then back to IDLE.
REQ-014 SHALL drive uart_tx low on the first clock edge after the accepted TX write (1-cycle latency) and set tx_ready=1 on the same edge that STOP completes; a complete frame is exactly 10*CLKS_PER_BIT cycles.
REQ-015 SHALL accept a new TX write in the same cycle tx_ready returns to 1; that frame starts with no idle bit between frames.
REQ-016 SHALL register uart_tx, so it is glitch-free.
REQ-017 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-018 SHALL run an RX FSM with states IDLE, START, DATA, STOP.
- IDLE to START: synchronized rx low.
- START: re-sample at CLKS_PER_BIT/2 (integer division). If high, return to IDLE as a glitch and record nothing; if low, go to DATA.
- DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
- STOP: sample the stop bit CLKS_PER_BIT later.
REQ-019 SHALL handle the stop sample as follows:
- Stop bit high: load rx_data, set rx_done=1 on the same edge, go to IDLE.
- Stop bit low (framing error): leave rx_data and rx_done unchanged, and wait in STOP until rx is high before returning to IDLE.
REQ-020 SHALL clear rx_done on any bus_wren with bus_addr=UART_RX_DONE; reads have no side effects.
REQ-021 SHALL let completion win when a clear write and an RX completion fall on the same edge: rx_done=1.
REQ-022 SHALL handle overrun by overwriting rx_data with the new byte while rx_done stays 1; no overrun flag exists.
REQ-023 SHALL use bit counters of 3 bits and a cycle counter of $clog2(CLKS_PER_BIT) bits; counters never wrap mid-bit.
REQ-024 SHALL ignore writes to UART_RX_ADDR and UART_TX_DONE, and to any non-UART address.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, force:
- both FSMs to IDLE and all counters to 0;
- uart_tx=1, tx_ready=1, rx_done=0, rx_data=8'h00, TX shift register=8'h00;
- synchronizer flops=1.
REQ-026 SHALL abort a frame in progress when rst is asserted: uart_tx returns high on that edge, and a partial RX byte is discarded.
REQ-027 SHALL ignore bus writes in any cycle with rst=1.

Verification
REQ-028 TX, CLKS_PER_BIT=4: write 32'h000001A5 to UART_TX_ADDR -> uart_tx, 4 cycles per bit, is 0,1,0,1,0,0,1,0,1,1 starting 1 cycle later; TX_DONE reads 0 for 40 cycles, then 1.
REQ-029 TX busy: a second write of 8'h3C issued 10 cycles into an 8'hA5 frame -> waveform identical to REQ-028; no 8'h3C frame is sent.
REQ-030 RX: drive a frame for 8'h5A at 4 cycles/bit -> RX_DONE reads 1 and RX_ADDR reads 32'h0000005A; a write to UART_RX_DONE -> RX_DONE reads 0 next cycle.
REQ-031 RX errors:
- 1-cycle low glitch on uart_rx -> rx_done stays 0.
- Frame 8'hFF with stop bit 0 -> rx_done stays 0 and rx_data is unchanged.
REQ-032 Reset mid-frame: assert rst for 1 cycle at cycle 15 of a TX frame and during an RX data bit -> uart_tx=1, TX_DONE=1, RX_DONE=0 next cycle; a subsequent 8'h81 TX and RX both complete correctly.
